dma_reg_posted_wr_buf: RTL and testbench
========================================

# dma_reg_posted_wr_buf

Posted-write buffer on the register interface, placed directly upstream of the register-to-AXI converter in the CVA6 descriptor DMA system. Writes are acknowledged as soon as they are queued, which hides AXI write latency from the core. Reads wait until every earlier write has completed downstream, then pass through with zero added latency. Read-after-write order is strictly preserved.

## Interface
- `reg_req_t`, default `logic`: register request struct (`addr`, `write`, `wdata`, `wstrb`, `valid`).
- `reg_rsp_t`, default `logic`: register response struct (`rdata`, `error`, `ready`).
- `Depth`, default `4`: number of write entries; must be ≥ 2.
- `CntWidth`, default `$clog2(Depth+1)`: width of the occupancy count (derived; do not override).
- `clk_i` in 1: clock. One clock domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `slv_req_i` in `reg_req_t`: request from the core side.
- `slv_rsp_o` out `reg_rsp_t`: response to the core side.
- `mst_req_o` out `reg_req_t`: request to the converter.
- `mst_rsp_i` in `reg_rsp_t`: response from the converter.
- `wr_pending_o` out `CntWidth`: queued writes plus the write in flight.
- `busy_o` out 1: `wr_pending_o != 0` or a read is forwarded.
- `wr_err_o` out 1: sticky; set when a posted write returns `error`.

## Operation
- Write accept: `slv_req_i.valid && write && count < Depth` (registered count) pushes {addr, wdata, wstrb}. `slv_rsp_o.ready=1` in the same cycle, `error=0`, `rdata=0`.
- Full: `slv_rsp_o.ready=0`; the core holds its request. A pop in the same cycle does not free the slot until the next cycle, so there is no combinational path from `mst_rsp_i` to the write ready.
- FSM states:
  - IDLE: FIFO non-empty → WR.
  - WR: drive the FIFO head on `mst_req_o` with `write=1` and `valid=1`, held stable. On `mst_rsp_i.ready`, pop; go to IDLE when count becomes 0, otherwise stay in WR and present the next head.
  - A read is served only in IDLE with an empty FIFO.
- Read forward, IDLE and empty: `mst_req_o` = `slv_req_i` combinationally. `slv_rsp_o.ready` = `mst_rsp_i.ready`. `rdata` and `error` pass through. No state change.
- Read while writes are pending: `slv_rsp_o.ready=0` and the master port stays on the write path until drained.
- `wr_err_o`: set on `mst_rsp_i.ready && error` in WR. Cleared only by reset.
- Count: +1 on push, −1 on pop. Simultaneous push and pop leaves it unchanged. Never exceeds `Depth`.
- Reset mid-operation: FIFO is flushed and the FSM goes to IDLE. The converter shares the reset, so a dropped in-flight request is acceptable.

## Timing
- Reset values: `mst_req_o` all zero (`valid=0`), `slv_rsp_o` all zero, `wr_pending_o=0`, `busy_o=0`, `wr_err_o=0`.
- Write latency:
  - Core ack in the request cycle (0 cycles).
  - Downstream `valid` rises at the earliest 1 cycle after the push.
- Back-to-back writes: one accepted per cycle until full. Downstream drain is one per `mst_rsp_i.ready`, which may be in consecutive cycles.
- Read latency: 0 added cycles when empty. Otherwise it waits for the drain cycles, and the read is forwarded in the cycle after the last pop.
- `mst_req_o` never changes while `valid=1 && !ready`, per the register protocol.

## Structure
- Package `dma_reg_buf_pkg`: FSM enum `state_e {IDLE, WR}`.
- The write entry struct is built in the module from the `reg_req_t` field types.
- One sub-module: common_cells `fifo_v3`, configured as follows:
  - `FALL_THROUGH=0`, `DEPTH=Depth`.
  - `rst_ni` driven by `~rst_i`.
  - `flush_i` tied to 0.
- FSM and the sticky error flag live in the top.

## Test plan
- Single write `0x10 ← 0xDEADBEEF`, `wstrb=0xF` → core ack cycle 0, `mst_req_o.valid` at cycle 1, `wr_pending_o` 1 → 0 after downstream ready.
- Downstream ready stalled → 5 writes: first 4 acked in cycles 0–3, 5th stalls with `ready=0`. Release ready → 5th accepted 1 cycle after the first pop, and order at the master is preserved.
- Write `0x20 ← 0x1` then read `0x20`, downstream 3-cycle write latency → read not forwarded until the write pops. Returns `0x1`, and the read appears on the master in the cycle after the pop.
- Read with an empty buffer, downstream ready after 2 cycles → `slv_rsp_o.ready` and `rdata` mirror the master response in the same cycle.
- Posted write answered with `error=1` → `wr_err_o` rises the next cycle and stays high through 10 further clean writes.
- Assert `rst_i` with 3 queued writes → all outputs return to their reset values immediately, and post-reset traffic works normally.

Source files
------------

// File: rtl/dma_reg_buf_pkg.sv
// Shared types for the posted-write register buffer.
//   state_e   : write-drain FSM states.
//   buf_req_t : default register request (32-bit address/data, byte strobes).
//   buf_rsp_t : default register response.
package dma_reg_buf_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WR   = 1'b1
  } state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 valid;
  } buf_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } buf_rsp_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 port set (test-mode input
// not provided).
//   clk_i/rst_ni     : clock, asynchronous active-low reset
//   flush_i          : synchronous clear of all entries
//   full_o/empty_o   : occupancy flags (registered state only)
//   usage_o          : occupancy count modulo 2**ADDR_DEPTH
//   data_i/push_i    : write side; a push while full is ignored
//   data_o/pop_i     : read side; data_o shows the head entry
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [31:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] LastIdx  = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0]   DepthCnt = (ADDR_DEPTH + 1)'(DEPTH);

  dtype                  mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic                  bypass, do_push, do_pop;

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];

  // In fall-through mode an entry pushed and popped while empty never lands
  // in storage.
  assign bypass  = FALL_THROUGH && empty_o && push_i && pop_i;
  assign do_push = push_i && !full_o && !bypass;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_ptr_q];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + ADDR_DEPTH'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + ADDR_DEPTH'(1);
      cnt_q <= cnt_q + (ADDR_DEPTH + 1)'(do_push) - (ADDR_DEPTH + 1)'(do_pop);
    end
  end

  // NOTE: storage has no reset; the count and pointers decide which entries
  // are valid, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dma_reg_posted_wr_buf.sv
// Posted-write buffer in front of the register-to-AXI converter.
// Writes are acknowledged when queued; reads are held until all earlier
// writes have drained downstream, then pass through combinationally.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   slv_req_i/o   : core-side register port (slv_rsp_o is the response)
//   mst_req_o/i   : converter-side register port (mst_rsp_i is the response)
//   wr_pending_o  : queued writes including the one on the master port
//   busy_o        : writes pending or a read being forwarded
//   wr_err_o      : sticky, set when a posted write returns error
module dma_reg_posted_wr_buf
  import dma_reg_buf_pkg::*;
#(
  parameter type         reg_req_t = buf_req_t,
  parameter type         reg_rsp_t = buf_rsp_t,
  parameter int unsigned Depth     = 4,
  parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  reg_req_t            slv_req_i,
  output reg_rsp_t            slv_rsp_o,
  output reg_req_t            mst_req_o,
  input  reg_rsp_t            mst_rsp_i,
  output logic [CntWidth-1:0] wr_pending_o,
  output logic                busy_o,
  output logic                wr_err_o
);

  localparam int unsigned AddrDepth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned AddrW     = $bits(slv_req_i.addr);
  localparam int unsigned DataW     = $bits(slv_req_i.wdata);
  localparam int unsigned StrbW     = $bits(slv_req_i.wstrb);

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
    logic [StrbW-1:0] wstrb;
  } wr_entry_t;

  state_e               state_q, state_d;
  logic                 wr_err_q, wr_err_d;
  wr_entry_t            push_data, head;
  logic                 fifo_full, fifo_empty;
  logic [AddrDepth-1:0] fifo_usage;
  logic                 push, pop, rd_fwd;
  logic [CntWidth-1:0]  count, count_next;

  assign push_data = '{addr: slv_req_i.addr, wdata: slv_req_i.wdata, wstrb: slv_req_i.wstrb};

  // Write ready depends only on registered occupancy, so a pop in the same
  // cycle cannot open a slot combinationally.
  assign push = slv_req_i.valid && slv_req_i.write && !fifo_full;
  assign pop  = (state_q == WR) && mst_rsp_i.ready;

  // usage wraps to zero when full, so full supplies the top value.
  assign count      = fifo_full ? CntWidth'(Depth) : CntWidth'(fifo_usage);
  assign count_next = count + CntWidth'(push) - CntWidth'(pop);

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (Depth),
    .dtype        (wr_entry_t)
  ) i_wr_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (push_data),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    wr_err_d  = wr_err_q;
    mst_req_o = '0;
    slv_rsp_o = '0;
    rd_fwd    = 1'b0;

    if (push) slv_rsp_o.ready = 1'b1;

    unique case (state_q)
      IDLE: begin
        // IDLE always means the FIFO is empty: leaving WR requires count 0.
        if (fifo_empty && slv_req_i.valid && !slv_req_i.write) begin
          rd_fwd    = 1'b1;
          mst_req_o = slv_req_i;
          slv_rsp_o = mst_rsp_i;
        end
        // Moving on count_next lets valid rise the cycle after the push.
        if (count_next != '0) state_d = WR;
      end
      WR: begin
        mst_req_o.addr  = head.addr;
        mst_req_o.wdata = head.wdata;
        mst_req_o.wstrb = head.wstrb;
        mst_req_o.write = 1'b1;
        mst_req_o.valid = 1'b1;
        if (mst_rsp_i.ready) begin
          if (mst_rsp_i.error) wr_err_d = 1'b1;
          if (count_next == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_pending_o = count;
  assign busy_o       = (count != '0) || rd_fwd;
  assign wr_err_o     = wr_err_q;

endmodule

// File: tb/tb_dma_reg_posted_wr_buf.sv
// Self-checking bench for dma_reg_posted_wr_buf: queue-based reference model,
// per-cycle comparison, directed scenarios with literal expectations, then
// randomized traffic.
module tb_dma_reg_posted_wr_buf;
  import dma_reg_buf_pkg::*;

  localparam int unsigned Depth = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } ent_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  buf_req_t slv_req = '0, mst_req, core_req = '0;
  buf_rsp_t slv_rsp, mst_rsp = '0;
  logic [2:0] wr_pending;
  logic     busy, wr_err;
  logic     ds_ready = 1'b0, ds_error = 1'b0;

  dma_reg_posted_wr_buf #(
    .Depth (Depth)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv_req_i    (slv_req),
    .slv_rsp_o    (slv_rsp),
    .mst_req_o    (mst_req),
    .mst_rsp_i    (mst_rsp),
    .wr_pending_o (wr_pending),
    .busy_o       (busy),
    .wr_err_o     (wr_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queue of posted writes, sticky error, downstream memory.
  ent_t        q[$];
  logic        m_err = 1'b0;
  logic [31:0] mem[logic [31:0]];
  logic        exp_wr_acc = 1'b0, exp_fwd = 1'b0, acc = 1'b0;

  // Outputs observed in the most recent compare.
  buf_rsp_t    o_slv_rsp;
  buf_req_t    o_mst_req;
  logic [2:0]  o_pend;
  logic        o_busy, o_err;
  logic [31:0] seen_addr[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic buf_req_t mk_wr(input logic [31:0] a, input logic [31:0] d);
    buf_req_t r = '0;
    r.addr = a; r.wdata = d; r.wstrb = 4'hF; r.write = 1'b1; r.valid = 1'b1;
    return r;
  endfunction

  function automatic buf_req_t mk_rd(input logic [31:0] a);
    buf_req_t r = '0;
    r.addr = a; r.valid = 1'b1;
    return r;
  endfunction

  task automatic compare_all();
    buf_req_t e_req;
    buf_rsp_t e_rsp;
    exp_wr_acc = core_req.valid && core_req.write && (q.size() < Depth);
    exp_fwd    = (q.size() == 0) && core_req.valid && !core_req.write;
    o_slv_rsp = slv_rsp; o_mst_req = mst_req; o_pend = wr_pending;
    o_busy = busy; o_err = wr_err;

    if (q.size() > 0) begin
      e_req = '0;
      e_req.addr = q[0].addr; e_req.wdata = q[0].wdata; e_req.wstrb = q[0].wstrb;
      e_req.write = 1'b1; e_req.valid = 1'b1;
      check("mst_req_wr", 128'(mst_req), 128'(e_req));
    end else if (exp_fwd) begin
      check("mst_req_rd", 128'(mst_req), 128'(core_req));
    end else begin
      check("mst_valid_idle", 128'(mst_req.valid), 128'(1'b0));
    end

    if (exp_wr_acc) begin
      e_rsp = '0; e_rsp.ready = 1'b1;
      check("slv_rsp_wr", 128'(slv_rsp), 128'(e_rsp));
    end else if (exp_fwd) begin
      check("slv_rsp_rd", 128'(slv_rsp), 128'(mst_rsp));
    end else begin
      check("slv_ready_hold", 128'(slv_rsp.ready), 128'(1'b0));
    end

    check("wr_pending", 128'(wr_pending), 128'(q.size()));
    check("busy", 128'(busy), 128'((q.size() != 0) || exp_fwd));
    check("wr_err", 128'(wr_err), 128'(m_err));
    acc = exp_wr_acc || (exp_fwd && ds_ready);
  endtask

  // One clock: drive at negedge, answer as the converter, compare, then
  // advance the model at the posedge.
  task automatic tick();
    @(negedge clk);
    slv_req = core_req;
    #1;
    mst_rsp       = '0;
    mst_rsp.ready = ds_ready;
    mst_rsp.error = ds_error;
    mst_rsp.rdata = mst_req.write ? 32'($urandom) : mem_rd(mst_req.addr);
    #1;
    compare_all();
    @(posedge clk);
    if (o_mst_req.valid && o_mst_req.write && ds_ready) seen_addr.push_back(o_mst_req.addr);
    if (q.size() > 0 && ds_ready) begin
      mem[q[0].addr] = q[0].wdata;
      if (ds_error) m_err = 1'b1;
      void'(q.pop_front());
    end
    if (exp_wr_acc) q.push_back('{core_req.addr, core_req.wdata, core_req.wstrb});
  endtask

  task automatic send(input buf_req_t r);
    bit ok = 1'b0;
    core_req = r;
    for (int i = 0; i < 64 && !ok; i++) begin
      tick();
      ok = acc;
    end
    core_req = '0;
    if (!ok) check("send_timeout", 128'(ok), 128'(1'b1));
  endtask

  task automatic drain();
    ds_ready = 1'b1;
    ds_error = 1'b0;
    core_req = '0;
    for (int i = 0; i < 64 && q.size() != 0; i++) tick();
    tick();
    check("drain_empty", 128'(o_pend), 128'(0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    core_req = '0; slv_req = '0; mst_rsp = '0;
    ds_ready = 1'b0; ds_error = 1'b0;
    rst = 1'b1;
    #1;
    check({tag, "_slv_rsp"}, 128'(slv_rsp), 128'(0));
    check({tag, "_mst_req"}, 128'(mst_req), 128'(0));
    check({tag, "_pending"}, 128'(wr_pending), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_wr_err"}, 128'(wr_err), 128'(0));
    q.delete();
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset");

    // Single write: ack in cycle 0, valid in cycle 1, pending 1 -> 0.
    ds_ready = 1'b0;
    core_req = mk_wr(32'h10, 32'hDEADBEEF);
    tick();
    check("t1_ack", 128'(o_slv_rsp.ready), 128'(1));
    check("t1_valid_c0", 128'(o_mst_req.valid), 128'(0));
    core_req = '0;
    ds_ready = 1'b1;
    tick();
    check("t1_valid_c1", 128'(o_mst_req.valid), 128'(1));
    check("t1_addr", 128'(o_mst_req.addr), 128'(32'h10));
    check("t1_wdata", 128'(o_mst_req.wdata), 128'(32'hDEADBEEF));
    check("t1_pend1", 128'(o_pend), 128'(1));
    tick();
    check("t1_pend0", 128'(o_pend), 128'(0));

    // Stalled downstream: 4 accepted, 5th waits for a pop plus one cycle.
    ds_ready = 1'b0;
    seen_addr.delete();
    for (int i = 0; i < 5; i++) begin
      core_req = mk_wr(32'h100 + 32'(4 * i), 32'(i));
      tick();
      check($sformatf("t2_ack%0d", i), 128'(o_slv_rsp.ready), 128'(i < 4));
    end
    check("t2_full_pend", 128'(o_pend), 128'(4));
    ds_ready = 1'b1;
    tick();
    check("t2_pop_cycle", 128'(o_slv_rsp.ready), 128'(0));
    tick();
    check("t2_5th_acc", 128'(o_slv_rsp.ready), 128'(1));
    drain();
    check("t2_order_n", 128'(seen_addr.size()), 128'(5));
    for (int i = 0; i < 5 && i < seen_addr.size(); i++)
      check($sformatf("t2_order%0d", i), 128'(seen_addr[i]), 128'(32'h100 + 32'(4 * i)));

    // Read after write with 3-cycle downstream write latency.
    ds_ready = 1'b0;
    core_req = mk_wr(32'h20, 32'h1);
    tick();
    check("t3_wr_ack", 128'(o_slv_rsp.ready), 128'(1));
    core_req = mk_rd(32'h20);
    tick();
    check("t3_hold1", 128'(o_slv_rsp.ready), 128'(0));
    tick();
    check("t3_hold2", 128'(o_slv_rsp.ready), 128'(0));
    ds_ready = 1'b1;
    tick();
    check("t3_pop_write", 128'(o_mst_req.write), 128'(1));
    check("t3_hold3", 128'(o_slv_rsp.ready), 128'(0));
    tick();
    check("t3_rd_fwd", 128'({o_mst_req.valid, o_mst_req.write}), 128'(2'b10));
    check("t3_rd_addr", 128'(o_mst_req.addr), 128'(32'h20));
    check("t3_rd_ready", 128'(o_slv_rsp.ready), 128'(1));
    check("t3_rdata", 128'(o_slv_rsp.rdata), 128'(32'h1));
    core_req = '0;

    // Read with empty buffer, downstream ready after 2 cycles.
    ds_ready = 1'b0;
    core_req = mk_rd(32'h20);
    tick();
    check("t4_wait_ready", 128'(o_slv_rsp.ready), 128'(0));
    check("t4_fwd_valid", 128'(o_mst_req.valid), 128'(1));
    check("t4_busy", 128'(o_busy), 128'(1));
    tick();
    ds_ready = 1'b1;
    tick();
    check("t4_ready", 128'(o_slv_rsp.ready), 128'(1));
    check("t4_rdata", 128'(o_slv_rsp.rdata), 128'(32'h1));
    core_req = '0;

    // Posted write answered with error: sticky flag.
    ds_ready = 1'b1;
    ds_error = 1'b1;
    core_req = mk_wr(32'h30, 32'h5);
    tick();
    core_req = '0;
    tick();
    check("t5_err_same_cycle", 128'(o_err), 128'(0));
    ds_error = 1'b0;
    tick();
    check("t5_err_next", 128'(o_err), 128'(1));
    for (int i = 0; i < 10; i++) send(mk_wr(32'h40 + 32'(4 * i), 32'(i)));
    drain();
    check("t5_err_sticky", 128'(o_err), 128'(1));

    // Randomized traffic.
    core_req = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!core_req.valid || acc) begin
        if ($urandom_range(0, 9) < 7) begin
          if ($urandom_range(0, 9) < 6) begin
            core_req = mk_wr(32'(4 * $urandom_range(0, 15)), 32'($urandom));
            core_req.wstrb = 4'($urandom);
          end else begin
            core_req = mk_rd(32'(4 * $urandom_range(0, 15)));
          end
        end else begin
          core_req = '0;
        end
      end
      ds_ready = ($urandom_range(0, 2) != 0);
      ds_error = ($urandom_range(0, 15) == 0);
      tick();
    end
    drain();

    // Reset with three queued writes, then normal traffic.
    ds_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      core_req = mk_wr(32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
      tick();
    end
    core_req = '0;
    tick();
    check("t6_queued", 128'(o_pend), 128'(3));
    do_reset("t6_reset");
    send(mk_wr(32'h50, 32'h77));
    drain();
    ds_ready = 1'b1;
    send(mk_rd(32'h50));
    check("t6_post_rd", 128'(o_slv_rsp.rdata), 128'(32'h77));
    check("t6_post_err", 128'(o_err), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
